// File: rtl/fd_frame_sched.sv
// fd_frame_sched: frame-level sequencer for the 2-D finite-difference engine.
// Issues one start per frame and counts Dy-valid strobes against the expected
// grid size. Flags sample mismatch, timeout or abort, and reports done/err
// status to the host.
module fd_frame_sched #(
  parameter int FRAMES_W  = 8,
  parameter int N_SAMPLES = 4096,
  parameter int CNT_W     = 13,
  parameter int TIMEOUT   = 1024
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [FRAMES_W-1:0] i_cmd_frames,
  input  logic                i_abort,
  output logic                o_start,
  input  logic                i_busy,
  input  logic                i_dy_valid,
  output logic [FRAMES_W-1:0] o_frame_idx,
  output logic [CNT_W-1:0]    o_sample_cnt,
  output logic                o_frame_done,
  output logic                o_done,
  output logic                o_err,
  output logic [1:0]          o_err_code
);

  localparam int TMR_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(N_SAMPLES);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  localparam logic [1:0] ERR_MISMATCH = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
  localparam logic [1:0] ERR_ABORT    = 2'd3;

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, RUN, GAP, FIN} state_t;

  state_t              state_q, state_d;
  logic [FRAMES_W-1:0] frames_left_q, frames_left_d;
  logic [FRAMES_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          code_q, code_d;
  logic                err_q, err_d;
  logic                start_q, fdone_q, fdone_d, done_q;

  logic                accept, abort_ok;
  logic [CNT_W-1:0]    cnt_seen;

  assign accept   = i_cmd_valid && (state_q == IDLE);
  // Abort is only honoured while a command is in flight.
  assign abort_ok = i_abort && (state_q == START || state_q == WAIT_BUSY ||
                                state_q == RUN   || state_q == GAP);
  // Sample count including a strobe in this cycle, saturating at all-ones.
  assign cnt_seen = (i_dy_valid && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;

  // Next-state and datapath updates; abort overrides whatever the state decided.
  always_comb begin
    state_d       = state_q;
    frames_left_d = frames_left_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    tmr_d         = tmr_q;
    code_d        = code_q;
    err_d         = err_q;
    fdone_d       = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        frames_left_d = i_cmd_frames;
        idx_d         = '0;
        cnt_d         = '0;
        code_d        = '0;
        err_d         = 1'b0;
        state_d       = (i_cmd_frames == '0) ? FIN : START;
      end
      START: begin
        cnt_d   = '0;
        tmr_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        cnt_d = cnt_seen;
        if (i_busy) begin
          tmr_d   = '0;
          state_d = RUN;
        end else if (tmr_q == TMR_LAST) begin
          code_d  = ERR_TIMEOUT;
          err_d   = 1'b1;
          state_d = FIN;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      RUN: begin
        cnt_d = cnt_seen;
        tmr_d = i_dy_valid ? '0 : tmr_q + 1'b1;
        if (!i_busy) begin
          if (cnt_seen == CNT_FRAME) begin
            fdone_d       = 1'b1;
            frames_left_d = frames_left_q - 1'b1;
            state_d       = GAP;
          end else begin
            code_d  = ERR_MISMATCH;
            err_d   = 1'b1;
            state_d = FIN;
          end
        end else if (!i_dy_valid && tmr_q == TMR_LAST) begin
          code_d  = ERR_TIMEOUT;
          err_d   = 1'b1;
          state_d = FIN;
        end
      end
      GAP: begin
        if (frames_left_q == '0) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = START;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_ok) begin
      state_d       = FIN;
      code_d        = ERR_ABORT;
      err_d         = 1'b1;
      fdone_d       = 1'b0;
      frames_left_d = frames_left_q;
      idx_d         = idx_q;
    end
  end

  // State, counters and registered pulse outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q       <= IDLE;
      frames_left_q <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      tmr_q         <= '0;
      code_q        <= '0;
      err_q         <= 1'b0;
      start_q       <= 1'b0;
      fdone_q       <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      frames_left_q <= frames_left_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      tmr_q         <= tmr_d;
      code_q        <= code_d;
      err_q         <= err_d;
      start_q       <= (state_d == START);
      fdone_q       <= fdone_d;
      done_q        <= (state_d == FIN);
    end
  end

  assign o_cmd_ready  = (state_q == IDLE);
  assign o_start      = start_q;
  assign o_frame_idx  = idx_q;
  assign o_sample_cnt = cnt_q;
  assign o_frame_done = fdone_q;
  assign o_done       = done_q;
  assign o_err        = err_q;
  assign o_err_code   = code_q;

endmodule
